hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage core.
- Generates stall and flush controls for the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Handles three hazard sources: load-use hazards, taken branches/jumps resolved in EX, and multi-cycle mul/div operations in EX.
- Also holds the front end while instruction memory is not ready.

---
 rtl/hazard_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use, EX redirects, multi-cycle mul/div, imem wait.
// Optional perf counters (StallCycles, FlushCount) built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MdStartE,
  input  logic             ImemReadyF,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int CW = $clog2(MD_LATENCY);
  // The start cycle itself is one EX cycle, and the busy state exits one edge after reaching 0.
  localparam logic [CW-1:0] MD_LOAD = CW'(MD_LATENCY - 2);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lw_stall;

  assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    MdBusy  = 1'b0;
    case (state_q)
      RUN: begin
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (MdStartE) begin
          state_d = MD_BUSY;
          cnt_d   = MD_LOAD;
        end else if (lw_stall || !ImemReadyF) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MD_BUSY: begin
        // EX holds the mul/div, so redirect/load/start inputs are don't-care here.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
        MdBusy = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (StallF ? CNT_W'(1) : CNT_W'(0));
    flush_cnt_d = flush_cnt_q + ((PCSrcE && state_q == RUN) ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`else
  assign StallCycles = '0;
  assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + random bench for hazard_ctrl against a cycle-count reference model.
module tb_hazard_ctrl;
  localparam int MD_LATENCY = 4;
  localparam int CNT_W      = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       Rs1D, Rs2D, RdE;
  logic             LoadE, PCSrcE, MdStartE, ImemReadyF;
  logic             StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy;
  logic [CNT_W-1:0] StallCycles, FlushCount;

  hazard_ctrl #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE), .ImemReadyF(ImemReadyF),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .MdBusy(MdBusy),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: remaining busy cycles of a mul/div plus event tallies.
  int          md_left = 0;
  logic [31:0] m_stalls = 0;
  logic [31:0] m_flushes = 0;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy}
  function automatic logic [6:0] model_out();
    logic hit;
    hit = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (md_left > 0)      return 7'b1110011;
    else if (PCSrcE)      return 7'b0001100;
    else if (MdStartE)    return 7'b0000000;
    else if (hit)         return 7'b1100100;
    else if (!ImemReadyF) return 7'b1100100;
    else                  return 7'b0000000;
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag);
    check_vec({tag, ":ctl"}, 32'({StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy}),
              32'(model_out()));
    check_vec({tag, ":stallcyc"}, StallCycles, PERF ? m_stalls : 32'd0);
    check_vec({tag, ":flushcnt"}, FlushCount,  PERF ? m_flushes : 32'd0);
  endtask

  // Inputs are already set; check at negedge, advance model on posedge.
  task automatic cycle(input string tag);
    logic [6:0] e;
    @(negedge clk);
    check_now(tag);
    e = model_out();
    @(posedge clk);
    if (e[6]) m_stalls++;
    if (md_left == 0 && PCSrcE) m_flushes++;
    if (md_left > 0) md_left--;
    else if (MdStartE && !PCSrcE) md_left = MD_LATENCY - 1;
    #1;
  endtask

  task automatic set_in(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic ld, input logic pc, input logic md, input logic rdy);
    Rs1D = r1; Rs2D = r2; RdE = rd; LoadE = ld; PCSrcE = pc; MdStartE = md; ImemReadyF = rdy;
  endtask

  task automatic model_reset();
    md_left = 0; m_stalls = 0; m_flushes = 0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 1);
    #2;
    check_vec("reset_ctl", 32'({StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy}), 32'd0);
    check_vec("reset_cnt", StallCycles | FlushCount, 32'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // Perf scenario: one load-use, one 4-cycle mul/div, two taken branches.
    set_in(5, 0, 5, 1, 0, 0, 1); cycle("loaduse");
    set_in(5, 0, 5, 0, 0, 0, 1); cycle("loaduse_gone");
    set_in(0, 0, 0, 0, 0, 1, 1); cycle("md_start");
    set_in(0, 0, 0, 0, 0, 0, 1); cycle("md_busy1");
    set_in(0, 0, 0, 1, 1, 1, 0); cycle("md_busy2_ignored");
    set_in(0, 0, 0, 0, 0, 0, 1); cycle("md_busy3");
    check_vec("md_busy_last", {31'd0, MdBusy}, 32'd0);
    cycle("md_done");
    set_in(0, 3, 3, 1, 1, 0, 1); cycle("branch_over_lw");
    set_in(0, 0, 0, 0, 1, 0, 0); cycle("branch_over_imem");
    set_in(0, 0, 0, 0, 0, 0, 1); cycle("idle");
    check_vec("perf_stalls", StallCycles, PERF ? 32'd4 : 32'd0);
    check_vec("perf_flushes", FlushCount, PERF ? 32'd2 : 32'd0);

    set_in(0, 0, 0, 1, 0, 0, 1); cycle("x0_no_hazard");
    set_in(7, 9, 9, 1, 0, 0, 1); cycle("loaduse_rs2");
    set_in(7, 9, 9, 0, 0, 0, 1); cycle("no_load_same_reg");
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0); cycle("imem_wait");
    end
    set_in(0, 0, 0, 0, 0, 0, 1); cycle("imem_ready");

    // Asynchronous reset in the second busy cycle.
    set_in(0, 0, 0, 0, 0, 1, 1); cycle("md2_start");
    set_in(0, 0, 0, 0, 0, 0, 1); cycle("md2_busy1");
    #2 reset = 1'b1;
    #1 model_reset();
    check_vec("async_rst_ctl", 32'({StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy}), 32'd0);
    check_now("async_rst");
    #1 reset = 1'b0;
    cycle("after_rst_run");
    set_in(4, 0, 4, 1, 0, 0, 1); cycle("after_rst_lw");

    // Random phase: small register range to provoke hits.
    for (int i = 0; i < 400; i++) begin
      logic pc, md;
      pc = ($urandom_range(0, 5) == 0);
      md = !pc && ($urandom_range(0, 7) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), pc, md, ($urandom_range(0, 4) != 0));
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
